// File: rtl/bus_xcvr_reg.sv
// Registered bidirectional bus transceiver with per-direction storage registers and a
// guaranteed both-sides-Z turnaround window on every direction change.
module bus_xcvr_reg #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned TURN_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire  [WIDTH-1:0] a,
  inout  wire  [WIDTH-1:0] b,
  input  logic             oe_n,
  input  logic             dir,
  input  logic             sab,
  input  logic             sba,
  input  logic             cap_a,
  input  logic             cap_b,
  output logic             a_drv,
  output logic             b_drv,
  output logic             turn
);

  localparam int unsigned CntW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
  localparam logic [CntW-1:0] CntReload = CntW'(TURN_CYC - 1);

  typedef enum logic [1:0] {StOff, StDrvAb, StDrvBa, StTurn} state_e;

  state_e           r_state, w_state_nxt;
  logic             r_tgt, w_tgt_nxt;
  logic [CntW-1:0]  r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_reg_a, r_reg_b;
  logic             w_cur_ab;

  assign w_cur_ab = (r_state == StDrvAb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StOff;
      r_tgt   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tgt   <= w_tgt_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tgt_nxt   = r_tgt;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      StOff: begin
        if (!oe_n) w_state_nxt = dir ? StDrvAb : StDrvBa;
      end
      StDrvAb, StDrvBa: begin
        if (oe_n) begin
          w_state_nxt = StOff;
        end else if (dir != w_cur_ab) begin
          w_state_nxt = StTurn;
          w_tgt_nxt   = dir;
          w_cnt_nxt   = CntReload;
        end
      end
      StTurn: begin
        if (oe_n) begin
          w_state_nxt = StOff;
        end else if (dir != r_tgt) begin
          // Direction bounced mid-turnaround: restart the full Z window.
          w_tgt_nxt = dir;
          w_cnt_nxt = CntReload;
        end else if (r_cnt == '0) begin
          w_state_nxt = r_tgt ? StDrvAb : StDrvBa;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = StOff;
    endcase
  end

  // Storage samples the resolved bus, including this block's own drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_a <= '0;
      r_reg_b <= '0;
    end else begin
      if (cap_a) r_reg_a <= a;
      if (cap_b) r_reg_b <= b;
    end
  end

  // oe_n gates the drive combinationally so release does not wait for a clock edge.
  assign b_drv = (r_state == StDrvAb) & ~oe_n;
  assign a_drv = (r_state == StDrvBa) & ~oe_n;
  assign turn  = (r_state == StTurn);

  assign b = b_drv ? (sab ? r_reg_a : a) : {WIDTH{1'bz}};
  assign a = a_drv ? (sba ? r_reg_b : b) : {WIDTH{1'bz}};

endmodule

// File: tb/tb_bus_xcvr_reg.sv
// Scoreboard bench for bus_xcvr_reg: stimulus pushes model expectations, a monitor pops
// and compares them once per cycle just before the rising edge.
module tb_bus_xcvr_reg;

  localparam int W    = 8;
  localparam int TURN = 2;

  logic clk, rst_n, oe_n, dir, sab, sba, cap_a, cap_b;
  logic a_drv, b_drv, turn;
  logic [W-1:0] tb_a, tb_b;
  wire  [W-1:0] a, b;

  // The bench acts as the far side of each bus and backs off whenever the DUT drives it.
  assign a = a_drv ? {W{1'bz}} : tb_a;
  assign b = b_drv ? {W{1'bz}} : tb_b;

  bus_xcvr_reg #(.WIDTH(W), .TURN_CYC(TURN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .oe_n  (oe_n),
    .dir   (dir),
    .sab   (sab),
    .sba   (sba),
    .cap_a (cap_a),
    .cap_b (cap_b),
    .a_drv (a_drv),
    .b_drv (b_drv),
    .turn  (turn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         adrv;
    logic         bdrv;
    logic         trn;
    logic [W-1:0] va;
    logic [W-1:0] vb;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  // Reference model: which side is being driven (0 none, 1 onto B, 2 onto A), how many
  // Z cycles of turnaround remain, and the stored bus values.
  int           m_side;
  int           m_left;
  logic         m_tgt;
  logic [W-1:0] m_ra, m_rb;

  function automatic void chk(input string name, input logic [W-1:0] got, input logic [W-1:0] req);
    n_total++;
    if (got !== req) $display("FAIL %s: got %h, required %h (t=%0t)", name, got, req, $time);
    else n_pass++;
  endfunction

  // Monitor: samples two time units before each rising edge.
  always @(negedge clk) begin
    exp_t e;
    #3;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("a_drv", W'(a_drv), W'(e.adrv));
      chk("b_drv", W'(b_drv), W'(e.bdrv));
      chk("turn",  W'(turn),  W'(e.trn));
      chk("bus_a", a, e.va);
      chk("bus_b", b, e.vb);
    end
  end

  task automatic model_reset();
    m_side = 0;
    m_left = 0;
    m_tgt  = 1'b0;
    m_ra   = '0;
    m_rb   = '0;
  endtask

  task automatic cyc(input bit rst, input bit oe, input bit dr, input bit sa, input bit sb,
                     input bit ca, input bit cb, input logic [W-1:0] va, input logic [W-1:0] vb);
    exp_t e;
    @(negedge clk);
    #1;
    rst_n = rst; oe_n = oe; dir = dr; sab = sa; sba = sb; cap_a = ca; cap_b = cb;
    tb_a = va; tb_b = vb;
    if (!rst) model_reset();
    e.trn  = (m_left > 0);
    e.bdrv = !oe && m_left == 0 && m_side == 1;
    e.adrv = !oe && m_left == 0 && m_side == 2;
    e.va   = va;
    e.vb   = vb;
    if (e.bdrv) e.vb = sa ? m_ra : va;
    if (e.adrv) e.va = sb ? m_rb : vb;
    exp_q.push_back(e);
    @(posedge clk);
    if (rst) begin
      if (ca) m_ra = e.va;
      if (cb) m_rb = e.vb;
      if (oe) begin
        m_side = 0;
        m_left = 0;
      end else if (m_left > 0) begin
        if (dr != m_tgt) begin
          m_tgt  = dr;
          m_left = TURN;
        end else begin
          m_left--;
          if (m_left == 0) m_side = m_tgt ? 1 : 2;
        end
      end else if (m_side == 0) begin
        m_side = dr ? 1 : 2;
      end else if ((m_side == 1) != dr) begin
        m_side = 0;
        m_tgt  = dr;
        m_left = TURN;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; oe_n = 1'b0; dir = 1'b1; sab = 1'b0; sba = 1'b0;
    cap_a = 1'b0; cap_b = 1'b0; tb_a = 8'h5A; tb_b = 8'h00;
    model_reset();

    // Reset while enabled, then first edge drives A onto B.
    cyc(0, 0, 1, 0, 0, 0, 0, 8'h5A, 8'h00);
    cyc(0, 0, 1, 0, 0, 0, 0, 8'h5A, 8'h00);
    cyc(1, 0, 1, 0, 0, 0, 0, 8'h5A, 8'h00);
    cyc(1, 0, 1, 0, 0, 0, 0, 8'h5A, 8'h00);
    // Direction change with a full turnaround, then B onto A.
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0, 0, 8'h11, 8'hC3);
    // Back to A->B with a bounce at the first turnaround cycle.
    cyc(1, 0, 1, 0, 0, 0, 0, 8'h22, 8'hC3);
    cyc(1, 0, 0, 0, 0, 0, 0, 8'h22, 8'hC3);
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0, 0, 0, 0, 8'h22, 8'hC3);
    // Stored mode: capture 3C, then present FF live and select stored/live.
    cyc(1, 0, 1, 1, 0, 1, 0, 8'h3C, 8'h00);
    cyc(1, 0, 1, 1, 0, 0, 0, 8'hFF, 8'h00);
    cyc(1, 0, 1, 0, 0, 0, 0, 8'hFF, 8'h00);
    // B->A, then async release via oe_n.
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 1, 0, 1, 8'h00, 8'h96);
    cyc(1, 1, 0, 0, 1, 0, 0, 8'h00, 8'h96);
    cyc(1, 1, 0, 0, 1, 0, 0, 8'h00, 8'h96);
    // Reset mid-drive with reg_a = 77; stored drive afterwards shows 00.
    cyc(1, 0, 1, 0, 0, 1, 0, 8'h77, 8'h00);
    cyc(1, 0, 1, 1, 0, 0, 0, 8'h12, 8'h00);
    cyc(0, 0, 1, 1, 0, 0, 0, 8'h12, 8'h00);
    cyc(1, 0, 1, 1, 0, 0, 0, 8'h12, 8'h00);
    cyc(1, 0, 1, 1, 0, 0, 0, 8'h12, 8'h00);

    // Randomized traffic biased toward long enables and occasional direction changes.
    begin
      bit d = 1'b1;
      for (int i = 0; i < 800; i++) begin
        if ($urandom_range(0, 5) == 0) d = ~d;
        cyc($urandom_range(0, 60) != 0, $urandom_range(0, 9) == 0, d,
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            W'($urandom), W'($urandom));
      end
    end

    @(negedge clk);
    #4;
    n_total++;
    if (exp_q.size() != 0) $display("FAIL drain: got %0d pending, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
